// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches from a req/ack instruction memory into a small
// PC-tagged FIFO drained by decode; a redirect flushes buffered and in-flight words.

module inst_prefetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_req,
  input logic          imem_ack,
  input logic [31:0]   imem_addr,
  input logic [CW-1:0] count,
  input logic          out_valid
);

  // An unacknowledged request must hold its address until the memory answers.
  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)))
    else $error("imem_req or imem_addr changed before ack");

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH))
    else $error("fifo count exceeds DEPTH");

  a_valid_tracks_count: assert property (@(posedge clk) disable iff (!rst)
    out_valid == (count != {CW{1'b0}}))
    else $error("out_valid disagrees with fifo count");

endmodule

module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic [15:0] flush_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic          imem_req_r;
  logic [31:0]   imem_addr_r;
  logic [31:0]   fetch_pc_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          out_valid_r;
  logic [31:0]   out_inst_r;
  logic [31:0]   out_pc_r;
  logic [15:0]   flush_cnt_r;
  logic [31:0]   inst_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];

  logic          hold_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_s;
  logic          flush_hit_s;
  logic [31:0]   redir_pc_s;
  logic [31:0]   fetch_pc_next_s;
  logic          req_next_s;
  logic [31:0]   addr_next_s;
  logic [CW-1:0] count_next_s;
  logic [PW-1:0] wr_ptr_next_s;
  logic [PW-1:0] rd_ptr_next_s;
  logic          valid_next_s;
  logic [31:0]   inst_next_s;
  logic [31:0]   pc_next_s;

  // Next-state for the fetch FSM, request port, FIFO pointers and registered head.
  always_comb begin
    hold_s          = imem_req_r & ~imem_ack;
    redir_pc_s      = redirect_pc & 32'hFFFF_FFFC;
    push_s          = 1'b0;
    pop_s           = 1'b0;
    issue_s         = 1'b0;
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    req_next_s      = imem_req_r;
    addr_next_s     = imem_addr_r;

    case (state_r)
      ST_RUN: begin
        if (redirect) begin
          fetch_pc_next_s = redir_pc_s;
          if (hold_s) begin
            // The in-flight word is stale but the memory still owes us an ack.
            state_next_s = ST_DISCARD;
          end else begin
            req_next_s  = 1'b1;
            addr_next_s = redir_pc_s;
          end
        end else begin
          push_s  = imem_req_r & imem_ack;
          pop_s   = out_valid_r & out_ready;
          issue_s = 1'b1;
          if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
          end else begin
            fetch_pc_next_s = fetch_pc_r;
          end
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fetch_pc_next_s = redir_pc_s;
        end else begin
          fetch_pc_next_s = fetch_pc_r;
        end
        if (imem_req_r & imem_ack) begin
          state_next_s = ST_RUN;
          req_next_s   = 1'b1;
          addr_next_s  = fetch_pc_next_s;
        end else begin
          state_next_s = ST_DISCARD;
        end
      end
      default: begin
        state_next_s = ST_RUN;
        req_next_s   = 1'b0;
        addr_next_s  = fetch_pc_r;
      end
    endcase

    flush_hit_s = redirect & ((count_r != {CW{1'b0}}) | hold_s);

    if (redirect) begin
      count_next_s  = {CW{1'b0}};
      wr_ptr_next_s = {PW{1'b0}};
      rd_ptr_next_s = {PW{1'b0}};
    end else begin
      count_next_s  = count_r + CW'(push_s) - CW'(pop_s);
      wr_ptr_next_s = wr_ptr_r + PW'(push_s);
      rd_ptr_next_s = rd_ptr_r + PW'(pop_s);
    end

    // Issue decision sees this cycle's push and pop, so a drained slot refetches at once.
    if (issue_s) begin
      req_next_s = (count_next_s < DEPTH_C);
      if (hold_s) begin
        addr_next_s = imem_addr_r;
      end else begin
        addr_next_s = fetch_pc_next_s;
      end
    end else begin
      req_next_s  = req_next_s;
      addr_next_s = addr_next_s;
    end

    valid_next_s = (count_next_s != {CW{1'b0}});
    if (!valid_next_s) begin
      inst_next_s = 32'h0000_0000;
      pc_next_s   = 32'h0000_0000;
    end else if (push_s && (count_r == CW'(pop_s))) begin
      // The word being written this edge becomes the head: bypass the storage array.
      inst_next_s = imem_rdata;
      pc_next_s   = imem_addr_r;
    end else begin
      inst_next_s = inst_mem_r[rd_ptr_next_s];
      pc_next_s   = pc_mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= imem_addr_r;
    end
  end

  // Control state, request port, pointers, head registers and flush counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_RUN;
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
      fetch_pc_r  <= RESET_PC;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_inst_r  <= 32'h0000_0000;
      out_pc_r    <= 32'h0000_0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      state_r     <= state_next_s;
      imem_req_r  <= req_next_s;
      imem_addr_r <= addr_next_s;
      fetch_pc_r  <= fetch_pc_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= valid_next_s;
      out_inst_r  <= inst_next_s;
      out_pc_r    <= pc_next_s;
      if (flush_hit_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign out_valid = out_valid_r;
  assign out_inst  = out_inst_r;
  assign out_pc    = out_pc_r;
  assign flush_cnt = flush_cnt_r;

  inst_prefetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req_r),
    .imem_ack  (imem_ack),
    .imem_addr (imem_addr_r),
    .count     (count_r),
    .out_valid (out_valid_r)
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: memory model with programmable latency or
// manual ack, inputs driven and outputs sampled on the falling clock edge.

module tb_inst_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [15:0] flush_cnt;

  logic        auto_en;
  logic        man_ack;
  logic [3:0]  lat;
  logic [3:0]  wait_cnt = 4'd0;
  int          checks   = 0;
  int          failures = 0;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .flush_cnt   (flush_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack on the (lat+1)-th cycle of a request, or under manual control.
  assign imem_ack   = auto_en ? (imem_req && (wait_cnt == lat)) : man_ack;
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clk) begin
    if (!rst || !imem_req || imem_ack) wait_cnt <= 4'd0;
    else wait_cnt <= wait_cnt + 4'd1;
  end

  task automatic do_reset(input logic auto_mode, input logic [3:0] l);
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    man_ack = 1'b0; auto_en = auto_mode; lat = l;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    man_ack = 1'b0; auto_en = 1'b1; lat = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL rst_out_inst got=%h exp=0", out_inst); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    checks++; if (flush_cnt !== 16'h0) begin failures++; $display("FAIL rst_flush_cnt got=%h exp=0", flush_cnt); end
  endtask

  task automatic test_zero_wait;
    do_reset(1'b1, 4'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zw_first_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_first_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL zw_first_addr got=%h exp=0", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zw_valid[%0d] got=%0h exp=1", i, out_valid); end
      checks++; if (out_pc !== 32'(i * 4)) begin failures++; $display("FAIL zw_pc[%0d] got=%h exp=%h", i, out_pc, 32'(i * 4)); end
      checks++; if (out_inst !== mem_word(32'(i * 4))) begin failures++; $display("FAIL zw_inst[%0d] got=%h exp=%h", i, out_inst, mem_word(32'(i * 4))); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_latency_full;
    int   acks;
    logic seen_req;
    do_reset(1'b1, 4'd2);
    acks = 0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        checks++; if (imem_addr !== 32'(acks * 4)) begin failures++; $display("FAIL lat_ack_addr[%0d] got=%h exp=%h", acks, imem_addr, 32'(acks * 4)); end
        acks++;
      end
    end
    checks++; if (acks != 4) begin failures++; $display("FAIL lat_ack_count got=%0d exp=4", acks); end
    seen_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (imem_req) seen_req = 1'b1;
    end
    checks++; if (seen_req !== 1'b0) begin failures++; $display("FAIL lat_full_req got=%0h exp=0", seen_req); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_full_valid got=%0h exp=1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL lat_full_pc got=%h exp=0", out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL lat_pop_pc got=%h exp=4", out_pc); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL lat_refill_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL lat_refill_addr got=%h exp=10", imem_addr); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL lat_single_pop got=%h exp=4", out_pc); end
  endtask

  task automatic test_redirect_discard;
    do_reset(1'b0, 4'd0);
    @(negedge clk); man_ack = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL disc_full_req got=%0h exp=0", imem_req); end
    man_ack = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_pc !== 32'h8) begin failures++; $display("FAIL disc_pre_pc got=%h exp=8", out_pc); end
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin failures++; $display("FAIL disc_pre_req got=%0h/%h exp=1/10", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL disc_flush_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL disc_hold got=%0h/%h exp=1/10", imem_req, imem_addr); end
    checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL disc_flush_cnt got=%0d exp=1", flush_cnt); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL disc_hold2 got=%h exp=10", imem_addr); end
    man_ack = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL disc_drop_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL disc_new_req got=%0h/%h exp=1/40", imem_req, imem_addr); end
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin failures++; $display("FAIL disc_first_pc got=%0h/%h exp=1/40", out_valid, out_pc); end
    checks++; if (out_inst !== mem_word(32'h40)) begin failures++; $display("FAIL disc_first_inst got=%h exp=%h", out_inst, mem_word(32'h40)); end
    checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL disc_flush_cnt2 got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_redirect_with_ack;
    do_reset(1'b0, 4'd0);
    out_ready = 1'b1;
    @(negedge clk); man_ack = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (imem_addr !== 32'h14 || out_pc !== 32'h10) begin failures++; $display("FAIL rack_pre got=%h/%h exp=14/10", imem_addr, out_pc); end
    redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rack_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL rack_req got=%0h/%h exp=1/80", imem_req, imem_addr); end
    checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL rack_flush_cnt got=%0d exp=1", flush_cnt); end
    @(negedge clk);
    man_ack = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin failures++; $display("FAIL rack_first_pc got=%0h/%h exp=1/80", out_valid, out_pc); end
    checks++; if (out_inst !== mem_word(32'h80)) begin failures++; $display("FAIL rack_first_inst got=%h exp=%h", out_inst, mem_word(32'h80)); end
  endtask

  task automatic test_double_redirect;
    do_reset(1'b0, 4'd0);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL dbl_hold got=%0h/%h exp=1/0", imem_req, imem_addr); end
    man_ack = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h200 || out_valid !== 1'b0) begin failures++; $display("FAIL dbl_req got=%h/%0h exp=200/0", imem_addr, out_valid); end
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin failures++; $display("FAIL dbl_first_pc got=%0h/%h exp=1/200", out_valid, out_pc); end
    checks++; if (out_inst !== mem_word(32'h200)) begin failures++; $display("FAIL dbl_first_inst got=%h exp=%h", out_inst, mem_word(32'h200)); end
    checks++; if (flush_cnt !== 16'd2) begin failures++; $display("FAIL dbl_flush_cnt got=%0d exp=2", flush_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0, 4'd0);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect = 1'b0; man_ack = 1'b1;
    repeat (4) @(negedge clk);
    man_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || flush_cnt !== 16'd1) begin failures++; $display("FAIL mid_pre got=%0h/%0d exp=1/1", out_valid, flush_cnt); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL mid_pre_req got=%0h/%h exp=1/c", imem_req, imem_addr); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0h exp=0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%0h exp=0", imem_req); end
    checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL mid_flush_cnt got=%0d exp=0", flush_cnt); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=0", imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_restart got=%0h/%h exp=1/0", imem_req, imem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency_full();
    test_redirect_discard();
    test_redirect_with_ack();
    test_double_redirect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of the decode stage. It replaces the single-cycle combinational instruction ROM with a multi-cycle instruction-memory interface using a req/ack handshake. Fetched words are buffered, with their PCs, in a small FIFO that decode drains through a valid/ready handshake. A taken branch or jump from execute redirects fetch and flushes all buffered and in-flight instructions.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
imem_req  out  1  fetch request, registered
imem_addr  out  32  word-aligned fetch address, registered, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle; request complete
imem_rdata  in  32  instruction word, valid when imem_ack=1
redirect  in  1  taken branch/jump from execute, single-cycle pulse
redirect_pc  in  32  new fetch address; bits [1:0] treated as 0
out_valid  out  1  head entry valid
out_inst  out  32  head instruction; 0 when empty
out_pc  out  32  PC of head instruction; 0 when empty
out_ready  in  1  decode consumes head this cycle when out_valid=1
flush_cnt  out  16  saturating count of redirects that discarded at least one buffered or in-flight word

Behaviour:
- Reset: clk and rst are already decided. Reset is rst, synchronous, active-low; clock is clk.
- Reset values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO count=0, out_valid=0, out_inst=0, out_pc=0, flush_cnt=0, state=RUN.
- Reset applies mid-transaction. A pending request is abandoned; the memory is required to drop it.
- Handshake, memory side:
  - At most one outstanding request.
  - Once imem_req rises, it and imem_addr hold until a cycle with imem_ack=1.
  - ack may arrive in the same cycle req is first high (zero-wait memory).
  - ack while imem_req=0 is ignored.
- Issue rule (RUN): at each edge, imem_req_next = (count_next < DEPTH). count_next includes this cycle's push and pop.
  - On a push, imem_addr/fetch_pc advance by 4 (32-bit wrap).
  - With a zero-wait memory and a draining decode, throughput is 1 instruction/cycle.
- Push: on an edge with imem_req & imem_ack in RUN, {imem_addr, imem_rdata} is written at the tail. It is visible at out_* on the next cycle (1-cycle latency from ack to out_valid).
- Pop: out_valid & out_ready removes the head.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on an empty FIFO is a no-op.
- out_valid = (count != 0). out_* are driven from the registered FIFO head; there is no combinational path from imem_rdata.
- FSM states:
  - RUN: normal operation.
  - DISCARD: request outstanding, but its data is stale.
- Redirect in RUN:
  - FIFO flushes (count=0, pointers reset) at the edge; same-cycle pop and push are both dropped.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - If imem_req=1 and imem_ack=0 that cycle: go to DISCARD. Keep imem_req/imem_addr unchanged until ack.
  - Otherwise (no request, or ack in the same cycle): stay in RUN. Next cycle imem_req=1 with imem_addr=new fetch_pc.
- DISCARD:
  - On ack: drop imem_rdata and go to RUN. Next cycle, request fetch_pc.
  - Redirect in DISCARD only overwrites fetch_pc (last redirect wins).
  - Redirect and ack in the same cycle: drop the data, take the new fetch_pc, go to RUN.
  - FIFO stays empty in DISCARD; out_valid=0.
- flush_cnt increments by 1 on a redirect edge if count!=0 or a request is outstanding without ack. Saturates at 16'hFFFF.
- Full FIFO: imem_req stays 0 until a pop. Overflow is impossible by construction.
- Any redirect_pc value is legal; low bits are masked, no error is raised.

Test Plan:
- Zero-wait memory (ack=req), out_ready=1, RESET_PC=0 -> out_valid first high 2 cycles after rst release. out_pc sequence 0,4,8,12 on consecutive cycles; out_inst equals memory words.
- 3-cycle-latency memory, out_ready=0 -> exactly 4 pushes (out_pc 0..12 buffered), then imem_req stays 0. Raise out_ready for 1 cycle -> one pop, then a new req for addr 16.
- FIFO holding pc 8,12 plus outstanding req to 16 (no ack); redirect with redirect_pc=0x43 -> out_valid=0 next cycle, state DISCARD, imem_addr stays 16 until ack. Data from that ack is dropped. Next req addr=0x40; first out_pc=0x40; flush_cnt=1.
- Redirect to 0x80 in the same cycle as ack of addr 20 -> data dropped, next-cycle req addr 0x80, no DISCARD entry.
- Two redirects (0x100 then 0x200) while in DISCARD -> first delivered out_pc=0x200.
- Drive rst=0 mid-request with FIFO holding 3 entries -> next cycle out_valid=0, imem_req=0, flush_cnt=0. After release, first req addr=RESET_PC.
